// File: rtl/instr_sequencer.sv
// Instruction sequencer for a 13-bit accumulator machine: fetches from program memory,
// decodes one instruction per EXEC cycle and drives the ALU, accumulator and register-file strobes.
module instr_sequencer (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  PmAddr,
    output logic        PmReq,
    input  logic        PmValid,
    input  logic [12:0] PmData,
    output logic [2:0]  ALUCode,
    output logic        Ci,
    input  logic        Co,
    input  logic        AccuZero,
    output logic        AccuWe,
    output logic        RfWe,
    output logic [2:0]  RegAddr,
    output logic [7:0]  ImmOut,
    output logic        SrcSel,
    output logic        Halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [12:0] ir_q, ir_d;
    logic        cf_q, cf_d;
    logic [3:0]  op;
    logic [7:0]  operand;

    assign op      = ir_q[11:8];
    assign operand = ir_q[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= 8'd0;
            ir_q    <= 13'd0;
            cf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cf_q    <= cf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cf_d    = cf_q;
        PmReq   = 1'b0;
        ALUCode = 3'd7;
        Ci      = 1'b0;
        AccuWe  = 1'b0;
        RfWe    = 1'b0;
        SrcSel  = 1'b0;
        case (state_q)
            FETCH: begin
                PmReq = 1'b1;
                if (PmValid) begin
                    ir_d    = PmData;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                pc_d    = pc_q + 8'd1;
                // ALU ops 0-8 write the accumulator and always reload the carry
                if (op <= 4'd8) begin
                    AccuWe = 1'b1;
                    SrcSel = ir_q[12];
                    cf_d   = Co;
                end
                case (op)
                    4'h7: begin ALUCode = 3'd0; Ci = cf_q; end
                    4'h8: begin ALUCode = 3'd1; Ci = cf_q; end
                    4'h9: RfWe = 1'b1;
                    4'hA: pc_d = operand;
                    4'hB: if (AccuZero) pc_d = operand;
                    4'hC: if (cf_q) pc_d = operand;
                    4'hE: cf_d = 1'b0;
                    4'hF: begin state_d = HALT; pc_d = pc_q; end
                    default: if (op < 4'd7) ALUCode = op[2:0];
                endcase
            end
            HALT: ;
            default: state_d = FETCH;
        endcase
    end

    assign PmAddr  = pc_q;
    assign RegAddr = ir_q[2:0];
    assign ImmOut  = ir_q[7:0];
    assign Halted  = (state_q == HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed cycle table for the corner cases, then
// randomized instruction streams checked against an instruction-level model.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  PmAddr;
    logic        PmReq;
    logic        PmValid = 1'b0;
    logic [12:0] PmData = 13'd0;
    logic [2:0]  ALUCode;
    logic        Ci;
    logic        Co = 1'b0;
    logic        AccuZero = 1'b0;
    logic        AccuWe;
    logic        RfWe;
    logic [2:0]  RegAddr;
    logic [7:0]  ImmOut;
    logic        SrcSel;
    logic        Halted;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .PmAddr(PmAddr), .PmReq(PmReq), .PmValid(PmValid),
        .PmData(PmData), .ALUCode(ALUCode), .Ci(Ci), .Co(Co), .AccuZero(AccuZero),
        .AccuWe(AccuWe), .RfWe(RfWe), .RegAddr(RegAddr), .ImmOut(ImmOut),
        .SrcSel(SrcSel), .Halted(Halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, vld;
        logic [12:0] data;
        logic        co, az;
        logic [7:0]  addr;
        logic        req;
        logic [2:0]  alu;
        logic        ci, awe, rfwe, src, halt;
        logic [7:0]  imm;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // instruction-level reference state
    logic [7:0]  m_pc;
    logic [12:0] m_ir;
    logic        m_cf, m_have, m_halt;

    function automatic vec_t v(input logic r, vl, input logic [12:0] d, input logic c, z,
                               input logic [7:0] a, input logic q, input logic [2:0] al,
                               input logic ci_, aw, rf, sr, h, input logic [7:0] im);
        vec_t t;
        t.rst = r; t.vld = vl; t.data = d; t.co = c; t.az = z;
        t.addr = a; t.req = q; t.alu = al; t.ci = ci_; t.awe = aw; t.rfwe = rf;
        t.src = sr; t.halt = h; t.imm = im;
        return t;
    endfunction

    task automatic chk(input string tag, input string nm, input int act, input int exp);
        if (act != exp) begin
            $display("FAIL %s %s @%0t: got %0h want %0h", tag, nm, $time, act, exp);
            n_err++;
        end
    endtask

    task automatic cmp(input string tag, input vec_t e);
        n_vec++;
        chk(tag, "PmAddr",  int'(PmAddr),  int'(e.addr));
        chk(tag, "PmReq",   int'(PmReq),   int'(e.req));
        chk(tag, "ALUCode", int'(ALUCode), int'(e.alu));
        chk(tag, "Ci",      int'(Ci),      int'(e.ci));
        chk(tag, "AccuWe",  int'(AccuWe),  int'(e.awe));
        chk(tag, "RfWe",    int'(RfWe),    int'(e.rfwe));
        chk(tag, "SrcSel",  int'(SrcSel),  int'(e.src));
        chk(tag, "Halted",  int'(Halted),  int'(e.halt));
        chk(tag, "ImmOut",  int'(ImmOut),  int'(e.imm));
        chk(tag, "RegAddr", int'(RegAddr), int'(e.imm[2:0]));
        chk(tag, "AccuWe&RfWe", int'(AccuWe & RfWe), 0);
    endtask

    task automatic drive(input logic r, vl, input logic [12:0] d, input logic c, z);
        rst = r; PmValid = vl; PmData = d; Co = c; AccuZero = z;
    endtask

    // expected outputs from the model's view: waiting for a fetch, holding an instruction, or halted
    function automatic vec_t model_exp();
        vec_t e;
        logic [3:0] op;
        op = m_ir[11:8];
        e = v(1'b0, 1'b0, 13'd0, 1'b0, 1'b0, m_pc, !m_have && !m_halt, 3'd7,
              1'b0, 1'b0, 1'b0, 1'b0, m_halt, m_ir[7:0]);
        if (m_have) begin
            if (op < 4'd7)       e.alu = op[2:0];
            else if (op == 4'd7) e.alu = 3'd0;
            else if (op == 4'd8) e.alu = 3'd1;
            e.ci   = (op == 4'd7 || op == 4'd8) ? m_cf : 1'b0;
            e.awe  = (op <= 4'd8);
            e.rfwe = (op == 4'd9);
            e.src  = (op <= 4'd8) && m_ir[12];
        end
        return e;
    endfunction

    task automatic model_step(input logic vl, input logic [12:0] d, input logic c, z);
        logic [3:0] op;
        logic [7:0] nxt;
        op  = m_ir[11:8];
        nxt = m_pc + 8'd1;
        if (m_halt) begin
        end else if (m_have) begin
            m_have = 1'b0;
            if (op == 4'hA || (op == 4'hB && z) || (op == 4'hC && m_cf)) m_pc = m_ir[7:0];
            else if (op == 4'hF) m_halt = 1'b1;
            else m_pc = nxt;
            if (op <= 4'd8) m_cf = c;
            else if (op == 4'hE) m_cf = 1'b0;
        end else if (vl) begin
            m_ir   = d;
            m_have = 1'b1;
        end
    endtask

    initial begin
        // directed cycle table: inputs for the cycle, expected outputs during that cycle
        tbl.push_back(v(1,0,13'h0000,0,0, 8'h00,1,7,0,0,0,0,0,8'h00));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(0,0,13'h0000,0,0, 8'h00,1,7,0,0,0,0,0,8'h00));
        tbl.push_back(v(0,1,13'h1005,0,0, 8'h00,1,7,0,0,0,0,0,8'h00));
        tbl.push_back(v(0,0,13'h0000,1,0, 8'h00,0,0,0,1,0,1,0,8'h05));
        tbl.push_back(v(0,1,13'h1701,0,0, 8'h01,1,7,0,0,0,0,0,8'h05));
        tbl.push_back(v(0,0,13'h0000,0,0, 8'h01,0,0,1,1,0,1,0,8'h01));
        tbl.push_back(v(0,1,13'h0B40,0,0, 8'h02,1,7,0,0,0,0,0,8'h01));
        tbl.push_back(v(0,0,13'h0000,0,1, 8'h02,0,7,0,0,0,0,0,8'h40));
        tbl.push_back(v(0,1,13'h0B40,0,0, 8'h40,1,7,0,0,0,0,0,8'h40));
        tbl.push_back(v(0,0,13'h0000,0,0, 8'h40,0,7,0,0,0,0,0,8'h40));
        tbl.push_back(v(0,0,13'h0000,0,1, 8'h41,1,7,0,0,0,0,0,8'h40));
        tbl.push_back(v(0,1,13'h0AFF,0,0, 8'h41,1,7,0,0,0,0,0,8'h40));
        tbl.push_back(v(0,0,13'h0000,0,0, 8'h41,0,7,0,0,0,0,0,8'hFF));
        tbl.push_back(v(0,1,13'h0D00,0,0, 8'hFF,1,7,0,0,0,0,0,8'hFF));
        tbl.push_back(v(0,0,13'h0000,0,0, 8'hFF,0,7,0,0,0,0,0,8'h00));
        tbl.push_back(v(0,1,13'h1903,0,0, 8'h00,1,7,0,0,0,0,0,8'h00));
        tbl.push_back(v(0,1,13'h0000,0,0, 8'h00,0,7,0,0,1,0,0,8'h03));
        tbl.push_back(v(0,1,13'h0F00,0,0, 8'h01,1,7,0,0,0,0,0,8'h03));
        tbl.push_back(v(0,0,13'h0000,0,0, 8'h01,0,7,0,0,0,0,0,8'h00));
        tbl.push_back(v(0,1,13'h1005,0,0, 8'h01,0,7,0,0,0,0,1,8'h00));
        tbl.push_back(v(0,1,13'h1005,1,0, 8'h01,0,7,0,0,0,0,1,8'h00));
        tbl.push_back(v(1,0,13'h0000,0,0, 8'h00,1,7,0,0,0,0,0,8'h00));
        // reset in the middle of an ADD: strobes vanish at once, CF is cleared
        tbl.push_back(v(0,1,13'h0002,0,0, 8'h00,1,7,0,0,0,0,0,8'h00));
        tbl.push_back(v(0,0,13'h0000,1,0, 8'h00,0,0,0,1,0,0,0,8'h02));
        tbl.push_back(v(0,1,13'h0002,0,0, 8'h01,1,7,0,0,0,0,0,8'h02));
        tbl.push_back(v(1,0,13'h0000,1,0, 8'h00,1,7,0,0,0,0,0,8'h00));
        tbl.push_back(v(0,1,13'h0700,0,0, 8'h00,1,7,0,0,0,0,0,8'h00));
        tbl.push_back(v(0,0,13'h0000,0,0, 8'h00,0,0,0,1,0,0,0,8'h00));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].vld, tbl[i].data, tbl[i].co, tbl[i].az);
            #1;
            cmp($sformatf("tbl%0d", i), tbl[i]);
        end

        // randomized streams; the first cycle resets so the model starts aligned
        for (int c = 0; c < 3000; c++) begin
            logic        r, vl, co, az;
            logic [12:0] d;
            @(negedge clk);
            r  = (c == 0) || ($urandom_range(0, 199) == 0) || (m_halt && $urandom_range(0, 7) == 0);
            vl = ($urandom_range(0, 2) != 0);
            d  = 13'($urandom);
            if (d[11:8] == 4'hF && $urandom_range(0, 15) != 0) d[11:8] = 4'hD;
            co = 1'($urandom);
            az = 1'($urandom);
            drive(r, vl, d, co, az);
            #1;
            if (r) begin
                m_pc = 8'd0; m_ir = 13'd0; m_cf = 1'b0; m_have = 1'b0; m_halt = 1'b0;
            end
            cmp("rand", model_exp());
            if (!r) model_step(vl, d, co, az);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- PmAddr  out  8  program counter / program-memory address
- PmReq  out  1  instruction fetch request
- PmValid  in  1  program memory returns PmData this cycle
- PmData  in  13  instruction: [12] I (immediate), [11:8] op, [7:0] operand
- ALUCode  out  3  ALU operation select (ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, LD=6, 7=zero output)
- Ci  out  1  ALU carry in
- Co  in  1  ALU carry out
- AccuZero  in  1  accumulator content == 0
- AccuWe  out  1  accumulator write strobe
- RfWe  out  1  register-file write strobe (stores accumulator)
- RegAddr  out  3  register-file address = IR[2:0]
- ImmOut  out  8  immediate operand = IR[7:0]
- SrcSel  out  1  ALU DataIn source: 0 register file, 1 immediate
- Halted  out  1  sequencer stopped
REQ-002 There SHALL be no parameters.

Function
REQ-003 The FSM SHALL have states FETCH, EXEC and HALT only.
REQ-004 FETCH: PmReq=1 and PmAddr=PC held stable; on PmValid=1, IR<=PmData and next state is EXEC; otherwise remain in FETCH indefinitely.
REQ-005 EXEC SHALL last exactly one cycle; the minimum is 2 cycles per instruction, with execution in the cycle after PmValid.
REQ-006 PmValid outside FETCH SHALL be ignored.
REQ-007 Op decode in EXEC (PC+1 unless stated):
- 0-6: ALUCode=op, Ci=0, AccuWe=1
- 7 ADC: ALUCode=0, Ci=CF, AccuWe=1
- 8 SBC: ALUCode=1, Ci=CF, AccuWe=1
- 9 ST: RfWe=1, AccuWe=0
- A JMP: PC<=operand
- B JZ: PC<=operand if AccuZero=1, else PC+1
- C JC: PC<=operand if CF=1, else PC+1
- D NOP
- E CLC: CF<=0
- F HALT: next state HALT, PC unchanged
REQ-008 SrcSel SHALL equal IR[12] during EXEC of ops 0-8 and SHALL be 0 otherwise; I is ignored for ops 9-F.
REQ-009 Carry flag CF SHALL be loaded with Co at the end of EXEC for ops 0-8, so logic/LD ops clear it; it is unchanged by ops 9-D and F.
REQ-010 Outside EXEC: AccuWe=0, RfWe=0, ALUCode=7, Ci=0, SrcSel=0.
REQ-011 RegAddr and ImmOut SHALL always reflect IR.
REQ-012 PC increment SHALL be modulo 256 (0xFF -> 0x00).
REQ-013 JZ SHALL sample AccuZero in the EXEC cycle, reflecting the accumulator before any write in that cycle.
REQ-014 PmReq SHALL be 0 in EXEC and HALT.
REQ-015 HALT SHALL be left only via reset; Halted=1 exactly while in HALT.
REQ-016 AccuWe and RfWe SHALL never be asserted in the same cycle.

Reset
REQ-017 While rst=1 (asynchronously): state=FETCH, PC=0, IR=0, CF=0, Halted=0, and all strobes and REQ-010 defaults apply.
REQ-018 A reset asserted mid-FETCH or mid-EXEC SHALL abort the instruction with no strobe issued; fetch restarts at address 0 on the first edge after rst falls.

Verification
REQ-019 Reset, then PmValid held 0 for 5 cycles -> PmReq=1, PmAddr=0x00 stable, AccuWe=0 throughout.
REQ-020 Feed {I=1,op=0,0x05}, then {I=1,op=7,0x01} with Co=1 on the first -> first EXEC: ALUCode=0, Ci=0, SrcSel=1, ImmOut=0x05, AccuWe=1; second EXEC: ALUCode=0, Ci=1; PmAddr 0,1,2.
REQ-021 JZ 0x40 with AccuZero=1 -> next PmAddr=0x40; repeat with AccuZero=0 -> PmAddr=PC+1.
REQ-022 PC=0xFF executing NOP -> next PmAddr=0x00.
REQ-023 ST r3 then HALT -> RfWe=1, RegAddr=3 for one cycle; then Halted=1, PmReq=0, PmValid pulses ignored until rst.
REQ-024 Assert rst during EXEC of an ADD -> AccuWe drops immediately, CF=0, PmAddr=0x00 after release.
